// File: rtl/timer_pwm_ctrl.sv
// timer_pwm_ctrl: one-shot/continuous PWM counter engine behind the timer register block.
// Optional prescaler enabled by defining TIMER_PWM_PRESCALE_EN (adds the PRESC port).
module timer_pwm_ctrl #(
  parameter int   CNT_W    = 32,
  parameter logic PWM_IDLE = 1'b0
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             MODE,
  input  logic             GO_EN,
  input  logic [CNT_W-1:0] TOT_CNT,
  input  logic [CNT_W-1:0] DUTY_CNT,
`ifdef TIMER_PWM_PRESCALE_EN
  input  logic [7:0]       PRESC,
`endif
  output logic             IRQ_TRG,
  output logic             PWM_OUT,
  output logic             BUSY,
  output logic [CNT_W-1:0] CUR_CNT
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] tot_q, tot_d, duty_q, duty_d, cnt_q, cnt_d;
  logic mode_q, mode_d, pwm_q, pwm_d, irq_q, irq_d, cap, tick, last;
  assign last = cnt_q == tot_q - CNT_W'(1);
`ifdef TIMER_PWM_PRESCALE_EN
  logic [7:0] presc_q, presc_d, psc_q, psc_d;
  assign tick = psc_q == presc_q;
  always_comb begin
    presc_d = cap ? PRESC : presc_q;
    psc_d = (state_q == RUN && !tick) ? psc_q + 8'd1 : 8'd0;
  end
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      presc_q <= 8'd0;
      psc_q <= 8'd0;
    end else begin
      presc_q <= presc_d;
      psc_q <= psc_d;
    end
  end
`else
  assign tick = 1'b1;
`endif
  // Continuous wrap re-captures shadows on the last tick, so the next period starts without a gap.
  always_comb begin
    state_d = state_q;
    tot_d = tot_q;
    duty_d = duty_q;
    mode_d = mode_q;
    cnt_d = '0;
    irq_d = 1'b0;
    cap = 1'b0;
    case (state_q)
      IDLE: state_d = GO_EN ? LOAD : IDLE;
      LOAD: begin
        if (!GO_EN) state_d = IDLE;
        else begin
          cap = 1'b1;
          irq_d = TOT_CNT == '0;
          state_d = irq_d ? DONE : RUN;
        end
      end
      RUN: begin
        if (!GO_EN) state_d = IDLE;
        else if (!tick) cnt_d = cnt_q;
        else if (!last) cnt_d = cnt_q + CNT_W'(1);
        else begin
          irq_d = 1'b1;
          cap = mode_q;
          state_d = (mode_q && TOT_CNT != '0) ? RUN : DONE;
        end
      end
      DONE: state_d = !GO_EN ? IDLE : (mode_q && tot_q == '0) ? LOAD : DONE;
      default: state_d = IDLE;
    endcase
    if (cap) begin
      tot_d = TOT_CNT;
      duty_d = DUTY_CNT;
      mode_d = MODE;
    end
    pwm_d = (state_d == RUN) ? (cnt_d < duty_d) : PWM_IDLE;
  end
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      tot_q <= '0;
      duty_q <= '0;
      mode_q <= 1'b0;
      cnt_q <= '0;
      pwm_q <= PWM_IDLE;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tot_q <= tot_d;
      duty_q <= duty_d;
      mode_q <= mode_d;
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
      irq_q <= irq_d;
    end
  end
  assign IRQ_TRG = irq_q;
  assign PWM_OUT = pwm_q;
  assign BUSY = state_q != IDLE;
  assign CUR_CNT = cnt_q;
endmodule
